mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one data-memory port between the instruction-fetch requester (I) and the
//   MEM-stage requester (D: mreq/write/access_size/addr/wr_data).
//   Registered, one-transaction-at-a-time arbiter with a 3-state FSM.
//   Fixed priority D > I, with a bounded-burst rule so I is never starved.
//   Per-transaction timeout guards against a memory that never asserts ready.
// PARAMETERS
//   MAX_D_BURST  4    consecutive D grants allowed while I is pending; then I wins once
//   TIMEOUT      255  cycles in BUSY without m_ready before forced completion (>=1)
//   CNT_W        8    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   reset, synchronous, active-low
//   i_mreq       in   1   fetch request, level; held until i_ack
//   i_addr       in   32  fetch address; always a WORD read
//   i_rdata      out  32  fetch read data, valid while i_ack=1
//   i_ack        out  1   one-cycle completion pulse for I
//   d_mreq       in   1   data request, level; held until d_ack
//   d_write      in   1   1 = store, 0 = load
//   d_size       in   2   00 WORD, 01 HALF, 10 BYTE
//   d_addr       in   32  data address
//   d_wdata      in   32  store data
//   d_rdata      out  32  load data, raw (extension done upstream), valid while d_ack=1
//   d_ack        out  1   one-cycle completion pulse for D
//   m_mreq       out  1   memory request
//   m_write      out  1   memory write enable
//   m_size       out  2   memory access size
//   m_addr       out  32  memory address
//   m_wdata      out  32  memory write data
//   m_rdata      in   32  memory read data, sampled when m_ready=1
//   m_ready      in   1   memory completion, may be high the first cycle m_mreq is high
//   m_err        out  1   sticky timeout flag, cleared only by reset
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, every output and counter is 0.
//     An in-flight transaction is abandoned; no ack is issued.
//   All outputs are registered. States: IDLE, BUSY, RESP.
//   IDLE
//     If d_mreq && !(i_mreq && burst_cnt==MAX_D_BURST): grant D.
//     Else if i_mreq: grant I. Else stay in IDLE.
//     On grant: latch m_addr/m_size/m_write/m_wdata (I: size=00, write=0, wdata=0),
//       set m_mreq=1 and owner=grant, clear the timeout counter, go to BUSY.
//   BUSY
//     Hold all m_* outputs stable.
//     m_ready=1: m_mreq<=0; owner ack<=1; owner rdata<=m_rdata (0 for writes); go to RESP.
//     Else, when tcnt==TIMEOUT-1: m_err<=1, then same completion as above with rdata=0.
//     Else tcnt++.
//   RESP (exactly 1 cycle)
//     Ack is high. Requests are NOT sampled, so the requester can drop or change mreq.
//     Next: ack<=0, go to IDLE. rdata holds until the next ack.
//   burst_cnt
//     +1 (saturating) on each D grant made while i_mreq=1.
//     Cleared on any I grant, and on a D grant made while i_mreq=0.
//   Latency: request sampled in IDLE at cycle N -> m_mreq=1 from N+1 -> m_ready at cycle M
//     -> ack at M+1. Zero-wait memory: ack at N+2; peak throughput is 1 txn per 3 cycles.
//   Simultaneous i_mreq & d_mreq in IDLE: D wins unless burst limit reached.
//   Request changes while BUSY/RESP are ignored (inputs latched at grant).
//   m_ready while in IDLE/RESP: ignored.
//   m_rdata is never passed combinationally to i_rdata/d_rdata.
// STRUCTURE
//   Shared package mem_pkg: size codes WORD=2'b00, HALF=2'b01, BYTE=2'b10;
//     FSM encoding IDLE/BUSY/RESP; owner encoding OWN_I/OWN_D.
//   Single module. The grant/burst logic is a separate always block; no sub-module needed.
// TESTING
//   1 Only i_mreq=1, addr 0x100, m_ready tied 1 -> m_mreq at N+1, m_addr=0x100, m_size=00,
//     i_ack at N+2 with i_rdata=m_rdata; d_ack stays 0.
//   2 i_mreq and d_mreq both rise in the same cycle, d_write=1, d_wdata=0xDEADBEEF,
//     d_size=10 -> D is served first (m_write=1, m_size=10); I is served next transaction.
//   3 Both requesters held continuously, MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//   4 m_ready held 0 for TIMEOUT cycles -> m_err=1, owner ack with rdata=0; m_err stays 1
//     through later normal transactions.
//   5 rst_n=0 while BUSY -> next cycle all outputs 0, state IDLE, no ack issued;
//     after release a pending request is granted normally.
//   6 m_ready with 3 wait cycles on a D load -> m_* stable all 4 BUSY cycles,
//     d_ack exactly one cycle, d_rdata equals m_rdata sampled with m_ready.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the data-memory port arbiter.
// Access-size codes, FSM state encoding and transaction owner encoding.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between fetch (I) and MEM (D).
// One transaction at a time, D > I with a bounded D burst, per-txn timeout.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_mreq/i_addr       : fetch request (word read); i_rdata/i_ack response
//   d_mreq/d_write/d_size/d_addr/d_wdata : data request; d_rdata/d_ack response
//   m_mreq/m_write/m_size/m_addr/m_wdata : registered memory request
//   m_rdata/m_ready     : memory response; m_err sticky timeout flag
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mreq,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_mreq,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_mreq,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        m_err
);

    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             m_mreq_q, m_mreq_d;
    logic             m_write_q, m_write_d;
    logic [1:0]       m_size_q, m_size_d;
    logic [31:0]      m_addr_q, m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;
    logic             m_err_q, m_err_d;
    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic        win_d;
    logic        win_i;
    logic        tmo;
    logic [31:0] rd;

    // Grant and burst tracking: D wins unless I has waited out a full burst.
    always_comb begin
        win_d   = 1'b0;
        win_i   = 1'b0;
        burst_d = burst_q;
        if (state_q == ST_IDLE) begin
            if (d_mreq && !(i_mreq && burst_q == BURST_MAX)) begin
                win_d = 1'b1;
                if (!i_mreq) begin
                    burst_d = '0;
                end else if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end else if (i_mreq) begin
                win_i   = 1'b1;
                burst_d = '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tcnt_d    = tcnt_q;
        m_mreq_d  = m_mreq_q;
        m_write_d = m_write_q;
        m_size_d  = m_size_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_err_d   = m_err_q;
        i_ack_d   = i_ack_q;
        d_ack_d   = d_ack_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        tmo       = 1'b0;
        rd        = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_d || win_i) begin
                    state_d  = ST_BUSY;
                    owner_d  = win_d ? OWN_D : OWN_I;
                    tcnt_d   = '0;
                    m_mreq_d = 1'b1;
                    if (win_d) begin
                        m_write_d = d_write;
                        m_size_d  = d_size;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_write_d = 1'b0;
                        m_size_d  = SZ_WORD;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                tmo = !m_ready && (tcnt_q == TO_LAST);
                if (m_ready || tmo) begin
                    // Stores and timed-out loads return zero data.
                    rd       = (m_ready && !m_write_q) ? m_rdata : '0;
                    m_mreq_d = 1'b0;
                    m_err_d  = m_err_q | tmo;
                    state_d  = ST_RESP;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rd;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rd;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                i_ack_d = 1'b0;
                d_ack_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            tcnt_q    <= '0;
            burst_q   <= '0;
            m_mreq_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_size_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_err_q   <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tcnt_q    <= tcnt_d;
            burst_q   <= burst_d;
            m_mreq_q  <= m_mreq_d;
            m_write_q <= m_write_d;
            m_size_q  <= m_size_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_err_q   <= m_err_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_mreq  = m_mreq_q;
    assign m_write = m_write_q;
    assign m_size  = m_size_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_err   = m_err_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter.
// A transaction-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int MAXB = 4;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_mreq = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_mreq = 1'b0;
    logic        d_write = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_mreq;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;
    logic        m_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_D_BURST(MAXB),
        .TIMEOUT    (TMO),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_mreq (i_mreq),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_ack  (i_ack),
        .d_mreq (d_mreq),
        .d_write(d_write),
        .d_size (d_size),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack  (d_ack),
        .m_mreq (m_mreq),
        .m_write(m_write),
        .m_size (m_size),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_err  (m_err)
    );

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: expected outputs after each rising edge.
    logic        e_m_mreq = 0;
    logic        e_m_write = 0;
    logic [1:0]  e_m_size = 0;
    logic [31:0] e_m_addr = 0;
    logic [31:0] e_m_wdata = 0;
    logic        e_m_err = 0;
    logic        e_i_ack = 0;
    logic        e_d_ack = 0;
    logic [31:0] e_i_rdata = 0;
    logic [31:0] e_d_rdata = 0;
    bit          e_own_d = 0;
    int          cyc = 0;
    int          gcyc = 0;
    // Grant history: 0 = I, 1 = D with I idle, 2 = D with I waiting.
    int          hist[$];

    initial forever begin : model
        int burst;
        bit to;
        logic [31:0] rd;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            e_m_mreq = 0; e_m_write = 0; e_m_size = 0;
            e_m_addr = 0; e_m_wdata = 0; e_m_err = 0;
            e_i_ack = 0; e_d_ack = 0;
            e_i_rdata = 0; e_d_rdata = 0; e_own_d = 0;
            hist.delete();
        end else if (e_i_ack || e_d_ack) begin
            e_i_ack = 0;
            e_d_ack = 0;
        end else if (e_m_mreq) begin
            to = !m_ready && (cyc - gcyc == TMO);
            if (m_ready || to) begin
                rd = (m_ready && !e_m_write) ? m_rdata : 32'h0;
                if (to) e_m_err = 1;
                e_m_mreq = 0;
                if (e_own_d) begin
                    e_d_ack = 1; e_d_rdata = rd;
                end else begin
                    e_i_ack = 1; e_i_rdata = rd;
                end
            end
        end else begin
            burst = 0;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (hist[k] != 2) break;
                burst++;
            end
            if (d_mreq && !(i_mreq && burst >= MAXB)) begin
                e_own_d = 1; e_m_mreq = 1; gcyc = cyc;
                e_m_write = d_write; e_m_size = d_size;
                e_m_addr = d_addr; e_m_wdata = d_wdata;
                hist.push_back(i_mreq ? 2 : 1);
            end else if (i_mreq) begin
                e_own_d = 0; e_m_mreq = 1; gcyc = cyc;
                e_m_write = 0; e_m_size = SZ_WORD;
                e_m_addr = i_addr; e_m_wdata = 0;
                hist.push_back(0);
            end
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    initial forever begin : compare
        logic [134:0] act;
        logic [134:0] exp;
        @(negedge clk);
        if (check_en) begin
            act = {m_mreq, m_write, m_size, m_addr, m_wdata, m_err,
                   i_ack, d_ack, i_rdata, d_rdata};
            exp = {e_m_mreq, e_m_write, e_m_size, e_m_addr, e_m_wdata,
                   e_m_err, e_i_ack, e_d_ack, e_i_rdata, e_d_rdata};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle_compare t=%0t dut=%h model=%h",
                         $time, act, exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_ack(input bit is_d, input int bound,
                            output int k, output bit got);
        k = 0;
        got = 0;
        for (int c = 0; c < bound && !got; c++) begin
            @(posedge clk); #1;
            k++;
            if (is_d ? d_ack : i_ack) got = 1;
        end
    endtask

    initial begin
        int n;
        int k;
        bit got;
        logic [9:0] ord;

        repeat (2) @(negedge clk);
        rst_n = 1;
        check_en = 1;
        chk("reset_mreq", m_mreq, 0);
        chk("reset_err", m_err, 0);
        chk("reset_acks", {i_ack, d_ack}, 0);

        // Fetch only, zero-wait memory.
        @(negedge clk);
        i_mreq = 1; i_addr = 32'h100;
        m_ready = 1; m_rdata = 32'h12345678;
        @(posedge clk); #1;
        chk("t1_mreq", m_mreq, 1);
        chk("t1_addr", m_addr, 32'h100);
        chk("t1_size", m_size, SZ_WORD);
        chk("t1_noack", i_ack, 0);
        @(posedge clk); #1;
        chk("t1_iack", i_ack, 1);
        chk("t1_rdata", i_rdata, 32'h12345678);
        chk("t1_dack", d_ack, 0);
        chk("t1_model_ack", e_i_ack, 1);
        @(negedge clk);
        i_mreq = 0;
        @(negedge clk);

        // Simultaneous requests: D store first, then I.
        @(negedge clk);
        i_mreq = 1; i_addr = 32'h200;
        d_mreq = 1; d_write = 1; d_size = SZ_BYTE;
        d_addr = 32'h300; d_wdata = 32'hDEADBEEF;
        m_rdata = 32'h55AA33CC;
        @(posedge clk); #1;
        chk("t2_write", m_write, 1);
        chk("t2_size", m_size, SZ_BYTE);
        chk("t2_wdata", m_wdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t2_dack", d_ack, 1);
        chk("t2_iack", i_ack, 0);
        chk("t2_store_rdata", d_rdata, 0);
        @(negedge clk);
        d_mreq = 0; d_write = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t2_i_addr", m_addr, 32'h200);
        chk("t2_i_write", m_write, 0);
        @(posedge clk); #1;
        chk("t2_i_ack", i_ack, 1);
        @(negedge clk);
        i_mreq = 0;
        @(negedge clk);

        // Both held: bounded D burst.
        @(negedge clk);
        i_mreq = 1; i_addr = 32'h800;
        d_mreq = 1; d_size = SZ_WORD; d_addr = 32'h900;
        n = 0;
        ord = '0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(posedge clk); #1;
            if (d_ack) begin
                ord = {ord[8:0], 1'b1}; n++;
            end else if (i_ack) begin
                ord = {ord[8:0], 1'b0}; n++;
            end
        end
        chk("t3_order", {22'h0, ord}, 32'b1111011110);
        chk("t3_count", n, 10);
        @(negedge clk);
        i_mreq = 0; d_mreq = 0;
        @(negedge clk);

        // Timeout, then sticky error through a normal txn.
        @(negedge clk);
        d_mreq = 1; d_write = 0; d_addr = 32'h400;
        m_ready = 0; m_rdata = 32'hAAAA5555;
        wait_ack(1'b1, TMO + 20, k, got);
        chk("t4_ack_seen", got, 1);
        chk("t4_latency", k, TMO + 1);
        chk("t4_err", m_err, 1);
        chk("t4_rdata", d_rdata, 0);
        @(negedge clk);
        d_mreq = 0;
        @(negedge clk);
        @(negedge clk);
        i_mreq = 1; i_addr = 32'h500;
        m_ready = 1; m_rdata = 32'h11112222;
        wait_ack(1'b0, 10, k, got);
        chk("t4_i_ack", got, 1);
        chk("t4_i_rdata", i_rdata, 32'h11112222);
        chk("t4_err_sticky", m_err, 1);
        @(negedge clk);
        i_mreq = 0; m_ready = 0;
        @(negedge clk);

        // Reset while BUSY.
        @(negedge clk);
        d_mreq = 1; d_size = SZ_HALF; d_addr = 32'h600;
        @(posedge clk); #1;
        chk("t5_busy", m_mreq, 1);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        chk("t5_mreq", m_mreq, 0);
        chk("t5_addr", m_addr, 0);
        chk("t5_err", m_err, 0);
        chk("t5_acks", {i_ack, d_ack}, 0);
        chk("t5_irdata", i_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("t5_regrant", m_mreq, 1);
        chk("t5_noack", d_ack, 0);
        chk("t5_addr2", m_addr, 32'h600);
        @(negedge clk);
        m_ready = 1; m_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        chk("t5_dack", d_ack, 1);
        chk("t5_rdata", d_rdata, 32'h0BADF00D);
        @(negedge clk);
        d_mreq = 0; m_ready = 0;
        @(negedge clk);

        // D load with three wait cycles.
        @(negedge clk);
        d_mreq = 1; d_size = SZ_HALF; d_addr = 32'h700;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            chk("t6_mreq", m_mreq, 1);
            chk("t6_addr", m_addr, 32'h700);
            chk("t6_size", m_size, SZ_HALF);
            chk("t6_noack", d_ack, 0);
            @(negedge clk);
            d_addr = $urandom; d_size = SZ_BYTE;
            m_rdata = $urandom;
            if (j == 3) begin
                m_ready = 1; m_rdata = 32'hCAFEF00D;
            end
        end
        @(posedge clk); #1;
        chk("t6_dack", d_ack, 1);
        chk("t6_rdata", d_rdata, 32'hCAFEF00D);
        @(negedge clk);
        d_mreq = 0; m_ready = 0;
        @(posedge clk); #1;
        chk("t6_one_cycle", d_ack, 0);
        chk("t6_hold", d_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // Random traffic with a stall window and rare resets.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            if (i_mreq) begin
                if (i_ack) begin
                    if ($urandom_range(0, 1) != 0) i_mreq = 0;
                    else i_addr = $urandom;
                end
            end else if ($urandom_range(0, 99) < 40) begin
                i_mreq = 1; i_addr = $urandom;
            end
            if (d_mreq) begin
                if (d_ack) begin
                    if ($urandom_range(0, 1) != 0) d_mreq = 0;
                    d_write = 1'($urandom);
                    d_size = 2'($urandom_range(0, 2));
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 99) < 40) begin
                d_mreq = 1;
                d_write = 1'($urandom);
                d_size = 2'($urandom_range(0, 2));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (c >= 1200 && c < 1500) m_ready = 0;
            else m_ready = ($urandom_range(0, 99) < 55);
            m_rdata = $urandom;
        end

        @(negedge clk);
        rst_n = 1; i_mreq = 0; d_mreq = 0; m_ready = 1;
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
